// File: rtl/process_sequencer_if.sv
// Handshake bundle for process_sequencer: request/operand inputs from two
// requesters plus grant, completion, process state and idle lamp outputs.
interface process_sequencer_if;
    logic       req0;
    logic [1:0] code0;
    logic       req1;
    logic [1:0] code1;
    logic       gnt0;
    logic       gnt1;
    logic       done;
    logic [1:0] state;
    logic       l;

    // Requester side: drives requests/operands, observes results.
    modport master (
        output req0, code0, req1, code1,
        input  gnt0, gnt1, done, state, l
    );

    // Sequencer side.
    modport slave (
        input  req0, code0, req1, code1,
        output gnt0, gnt1, done, state, l
    );
endinterface

// File: rtl/process_sequencer.sv
// process_sequencer: two-requester arbiter that runs one transaction at a
// time through GRANT -> APPLY (HOLD_CYCLES) -> DONE and updates a 2-bit
// process state from the winner's latched operand via process_module.
// Optional build macro PROC_SEQ_PRIO_EN: fixed priority (req0 wins ties)
// instead of round-robin; the last-served pointer is then removed.

// Next-state logic for the process state; holds r when not busy.
module process_module (
    input  logic [1:0] r,
    input  logic [1:0] b,
    input  logic       n,
    output logic [1:0] f
);
    logic f1, f0;

    assign f1 = r[1] | (r[0] & b[1] & b[0]);
    assign f0 = (r[0] & ~b[1]) | (r[1] & r[0]) | (~r[0] & b[1] & b[0]) | (~r[1] & b[1] & ~b[0]);
    assign f  = n ? {f1, f0} : r;
endmodule

module process_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    process_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        APPLY = 2'b10,
        DONE  = 2'b11
    } fsm_t;

    fsm_t       fsm_q, fsm_d;
    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] code_q, code_d;
    logic       win_q, win_d;   // 0: requester 0, 1: requester 1
    logic       busy;
    logic       pick;
    logic [1:0] f;

    assign busy = (fsm_q != IDLE);

    process_module u_pm (
        .r (state_q),
        .b (code_q),
        .n (busy),
        .f (f)
    );

`ifdef PROC_SEQ_PRIO_EN
    // Fixed priority: requester 1 only wins when requester 0 is quiet.
    always_comb begin
        pick = ~bus.req0;
    end
`else
    logic last_q, last_d;       // last served requester

    // Round-robin: on a tie serve the requester not served last.
    always_comb begin
        pick = ~bus.req0;
        if (bus.req0 && bus.req1) pick = ~last_q;
    end

    // Pointer moves to the winner when its transaction completes.
    always_comb begin
        last_d = last_q;
        if (fsm_q == DONE) last_d = win_q;
    end

    // Pointer register; reset to "last served 1" so req0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

    // Transaction sequencing and process-state update.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        win_d   = win_q;
        case (fsm_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    fsm_d  = GRANT;
                    win_d  = pick;
                    code_d = pick ? bus.code1 : bus.code0;
                end
            end
            GRANT: begin
                fsm_d = APPLY;
                cnt_d = 4'(HOLD_CYCLES - 1);
            end
            APPLY: begin
                if (cnt_q == 4'd0) begin
                    state_d = f;
                    fsm_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any transaction with no state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= 2'b00;
            cnt_q   <= 4'd0;
            code_q  <= 2'b00;
            win_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            win_q   <= win_d;
        end
    end

    assign bus.gnt0  = (fsm_q == GRANT) && !win_q;
    assign bus.gnt1  = (fsm_q == GRANT) &&  win_q;
    assign bus.done  = (fsm_q == DONE);
    assign bus.state = state_q;
    assign bus.l     = ~busy;
endmodule
